// File: rtl/dphy_pkg.sv
// -----------------------------------------------------------------------------
// dphy_pkg
// Shared definitions for the D-PHY low-power receive path.
//   - LP line-state encodings, read as {Dp, Dn}
//   - LPRX line-state FSM state type
// -----------------------------------------------------------------------------
package dphy_pkg;

    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP10 = 2'b10;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    typedef enum logic [2:0] {
        INIT,
        STOP,
        HS_RQST,
        HS_PREP,
        HS_ACTIVE
    } lprx_state_e;

endpackage

// File: rtl/dphy_sync2.sv
// -----------------------------------------------------------------------------
// dphy_sync2
// Two-flop synchroniser for asynchronous level inputs. Both stages clear to 0
// on a synchronous active-high reset.
//   clk  in   sampling clock
//   rst  in   synchronous active-high reset
//   d    in   asynchronous inputs [WIDTH-1:0]
//   q    out  synchronised outputs [WIDTH-1:0], two clk edges behind d
// -----------------------------------------------------------------------------
module dphy_sync2 #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;

    // NOTE: non-blocking assignments let both stages sample the old values on
    // the same edge, which is what makes this a two-stage pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/dphy_lp_rx.sv
// -----------------------------------------------------------------------------
// dphy_lp_rx
// Low-power line-state receiver for one D-PHY data lane. Tracks the LP line
// state and recognises the HS entry sequence LP-11 -> LP-01 -> LP-00. After
// D_TERM_EN_TIME cycles in LP-00 it raises HSRX_EN to enable the HS receiver
// and termination; LP-11 drops it again.
//   LPRX_CLK  in   LP receive clock, all logic on the rising edge
//   RxRst     in   synchronous active-high reset (also clears synchroniser)
//   LPEnable  in   LP receiver enable, 0 holds the FSM in INIT
//   LP_Dp     in   LP comparator, positive line (asynchronous)
//   LP_Dn     in   LP comparator, negative line (asynchronous)
//   HSRX_EN   out  HS receiver/termination enable (registered)
// -----------------------------------------------------------------------------
module dphy_lp_rx
    import dphy_pkg::*;
#(
    parameter int D_TERM_EN_TIME = 6
) (
    input  logic LPRX_CLK,
    input  logic RxRst,
    input  logic LPEnable,
    input  logic LP_Dp,
    input  logic LP_Dn,
    output logic HSRX_EN
);

    localparam int                CNT_W    = $clog2(D_TERM_EN_TIME + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(D_TERM_EN_TIME - 1);

    logic [1:0]       line;
    lprx_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // The synchroniser keeps sampling while LPEnable is low so the FSM sees a
    // settled line value as soon as it is re-enabled.
    dphy_sync2 #(
        .WIDTH (2)
    ) u_sync (
        .clk (LPRX_CLK),
        .rst (RxRst),
        .d   ({LP_Dp, LP_Dn}),
        .q   (line)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;     // counter only survives while counting in HS_PREP

        case (state)
            INIT: begin
                if (line == LP11) state_nxt = STOP;
            end

            STOP: begin
                // LP-10 would be escape entry, which is unsupported: treat it
                // as a protocol error together with LP-00.
                case (line)
                    LP11:    state_nxt = STOP;
                    LP01:    state_nxt = HS_RQST;
                    default: state_nxt = INIT;
                endcase
            end

            HS_RQST: begin
                case (line)
                    LP00:    state_nxt = HS_PREP;
                    LP01:    state_nxt = HS_RQST;
                    LP11:    state_nxt = STOP;
                    default: state_nxt = INIT;
                endcase
            end

            HS_PREP: begin
                case (line)
                    LP00: begin
                        // Entry cycle counts as the first; CNT_LAST is reached
                        // after D_TERM_EN_TIME cycles, so the counter never wraps.
                        if (cnt == CNT_LAST) state_nxt = HS_ACTIVE;
                        else                 cnt_nxt   = cnt + 1'b1;
                    end
                    LP11:    state_nxt = STOP;
                    default: state_nxt = INIT;
                endcase
            end

            HS_ACTIVE: begin
                // HS swings look like LP-00 to the LP comparators; only a
                // clean LP-11 ends the burst.
                if (line == LP11) state_nxt = STOP;
            end

            default: state_nxt = INIT;
        endcase
    end

    // RxRst and LPEnable==0 have the same effect on the FSM side; only RxRst
    // additionally clears the synchroniser.
    always_ff @(posedge LPRX_CLK) begin
        if (RxRst || !LPEnable) begin
            state   <= INIT;
            cnt     <= '0;
            HSRX_EN <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            HSRX_EN <= (state_nxt == HS_ACTIVE);
        end
    end

endmodule

// File: tb/tb_dphy_lp_rx.sv
// -----------------------------------------------------------------------------
// tb_dphy_lp_rx
// Self-checking bench for dphy_lp_rx with D_TERM_EN_TIME = 6. Each stimulus
// segment holds one line value for n cycles; for every cycle the expected
// HSRX_EN after that edge is pushed to a scoreboard queue and popped once the
// edge has happened. Within a segment, HSRX_EN is expected high for cycle
// indices in [hi_from, hi_until), derived from the 2-edge input latency and
// the 2+D_TERM_EN_TIME entry latency.
// -----------------------------------------------------------------------------
module tb_dphy_lp_rx;
    import dphy_pkg::*;

    localparam int TERM = 6;

    logic LPRX_CLK = 1'b0;
    logic RxRst    = 1'b1;
    logic LPEnable = 1'b0;
    logic LP_Dp    = 1'b1;
    logic LP_Dn    = 1'b1;
    logic HSRX_EN;

    int n_checks = 0;
    int n_errors = 0;
    logic exp_q[$];

    dphy_lp_rx #(
        .D_TERM_EN_TIME (TERM)
    ) dut (
        .LPRX_CLK (LPRX_CLK),
        .RxRst    (RxRst),
        .LPEnable (LPEnable),
        .LP_Dp    (LP_Dp),
        .LP_Dn    (LP_Dn),
        .HSRX_EN  (HSRX_EN)
    );

    always #5 LPRX_CLK = ~LPRX_CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Hold one line value for n cycles with the given enable/reset levels.
    task automatic seg(input string tag, input logic [1:0] ln, input int n,
                       input logic en, input logic rst,
                       input int hi_from, input int hi_until);
        for (int i = 0; i < n; i++) begin
            @(negedge LPRX_CLK);
            {LP_Dp, LP_Dn} = ln;
            LPEnable       = en;
            RxRst          = rst;
            exp_q.push_back((i >= hi_from) && (i < hi_until));
            @(posedge LPRX_CLK);
            #1;
            check(tag, {31'd0, HSRX_EN}, {31'd0, exp_q.pop_front()});
        end
    endtask

    task automatic check_state(input string tag, input lprx_state_e exp);
        check(tag, 32'(dut.state), 32'(exp));
    endtask

    initial begin
        // Reset and idle
        seg("rst",        LP11, 5, 1'b0, 1'b1, 0, 0);
        check_state("rst_state", INIT);
        seg("idle_dis",   LP11, 5, 1'b0, 1'b0, 0, 0);
        check_state("idle_state", INIT);

        // Nominal HS entry: rise 2+TERM edges after first LP-00 capture
        seg("nom_lp11",   LP11, 10, 1'b1, 1'b0, 0, 0);
        check_state("nom_stop", STOP);
        seg("nom_lp01",   LP01, 10, 1'b1, 1'b0, 0, 0);
        check_state("nom_rqst", HS_RQST);
        seg("nom_lp00",   LP00, 30, 1'b1, 1'b0, 2 + TERM, 30);
        check_state("nom_active", HS_ACTIVE);

        // HS exit: still high for the 2 pipeline edges, then low
        seg("exit_lp11",  LP11, 10, 1'b1, 1'b0, 0, 2);
        check_state("exit_stop", STOP);

        // Re-entry restarts the full count
        seg("re_lp01",    LP01, 5,  1'b1, 1'b0, 0, 0);
        seg("re_lp00",    LP00, 12, 1'b1, 1'b0, 2 + TERM, 12);
        seg("re_exit",    LP11, 6,  1'b1, 1'b0, 0, 2);

        // Abort in HS_PREP after 3 cycles of LP-00
        seg("ab_lp01",    LP01, 5,  1'b1, 1'b0, 0, 0);
        seg("ab_lp00",    LP00, 3,  1'b1, 1'b0, 0, 0);
        seg("ab_lp11",    LP11, 10, 1'b1, 1'b0, 0, 0);
        check_state("ab_stop", STOP);

        // Protocol error: LP-10 from STOP
        seg("pe1_lp10",   LP10, 3,  1'b1, 1'b0, 0, 0);
        seg("pe1_lp00",   LP00, 20, 1'b1, 1'b0, 0, 0);
        check_state("pe1_init", INIT);
        seg("pe1_lp11",   LP11, 5,  1'b1, 1'b0, 0, 0);
        check_state("pe1_stop", STOP);

        // Protocol error: LP-10 during request
        seg("pe2_lp01",   LP01, 4,  1'b1, 1'b0, 0, 0);
        seg("pe2_lp10",   LP10, 4,  1'b1, 1'b0, 0, 0);
        check_state("pe2_init", INIT);
        seg("pe2_lp11",   LP11, 5,  1'b1, 1'b0, 0, 0);

        // LPEnable drop while active: low on the next edge
        seg("en_lp01",    LP01, 4,  1'b1, 1'b0, 0, 0);
        seg("en_lp00",    LP00, 10, 1'b1, 1'b0, 2 + TERM, 10);
        seg("en_drop",    LP00, 3,  1'b0, 1'b0, 0, 0);
        check_state("en_init", INIT);
        // Re-enable with the line parked at LP-00: stays idle
        seg("en_park",    LP00, 12, 1'b1, 1'b0, 0, 0);
        check_state("en_park_init", INIT);
        seg("en2_lp11",   LP11, 4,  1'b1, 1'b0, 0, 0);
        seg("en2_lp01",   LP01, 4,  1'b1, 1'b0, 0, 0);
        seg("en2_lp00",   LP00, 10, 1'b1, 1'b0, 2 + TERM, 10);

        // RxRst while active: low on the next edge
        seg("rst_hit",    LP00, 1,  1'b1, 1'b1, 0, 0);
        check_state("rst_hit_init", INIT);
        seg("rst_park",   LP00, 10, 1'b1, 1'b0, 0, 0);
        check_state("rst_park_init", INIT);

        // Single-cycle LP-01 request is still accepted
        seg("sh_lp11",    LP11, 4,  1'b1, 1'b0, 0, 0);
        seg("sh_lp01",    LP01, 1,  1'b1, 1'b0, 0, 0);
        seg("sh_lp00",    LP00, 10, 1'b1, 1'b0, 2 + TERM, 10);
        check_state("sh_active", HS_ACTIVE);
        seg("sh_exit",    LP11, 4,  1'b1, 1'b0, 0, 2);
        check_state("sh_stop", STOP);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
